// File: rtl/arm_mc_ctrl_stall_pkg.sv
// Shared types and encodings for the stall-aware multicycle ARM control unit.
package arm_mc_ctrl_stall_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_FAULT    = 4'd10
    } state_t;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    typedef struct packed {
        logic [1:0] ctrl;
        logic       nowrite;
        logic       flagw_cv;
    } alu_dec_t;

    // Data-processing cmd decode; unknown cmds fall back to a flag-free, write-free ADD.
    function automatic alu_dec_t alu_decode(input logic [3:0] cmd);
        alu_dec_t d;
        d = '{ctrl: ALU_ADD, nowrite: 1'b1, flagw_cv: 1'b0};
        case (cmd)
            CMD_ADD: d = '{ctrl: ALU_ADD, nowrite: 1'b0, flagw_cv: 1'b1};
            CMD_SUB: d = '{ctrl: ALU_SUB, nowrite: 1'b0, flagw_cv: 1'b1};
            CMD_AND: d = '{ctrl: ALU_AND, nowrite: 1'b0, flagw_cv: 1'b0};
            CMD_ORR: d = '{ctrl: ALU_ORR, nowrite: 1'b0, flagw_cv: 1'b0};
            CMD_CMP: d = '{ctrl: ALU_SUB, nowrite: 1'b1, flagw_cv: 1'b1};
            default: d = '{ctrl: ALU_ADD, nowrite: 1'b1, flagw_cv: 1'b0};
        endcase
        return d;
    endfunction

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/arm_mc_ctrl_stall_condlogic.sv
// Condition logic: architectural NZCV flags register, CondEx evaluation and
// FlagW-gated flag capture.
module arm_mc_ctrl_stall_condlogic
    import arm_mc_ctrl_stall_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] aluflags,
    input  logic       flag_upd,
    input  logic [1:0] flagw,
    output logic       condex
);

    logic [3:0] flags;
    logic       n;
    logic       z;
    logic       c;
    logic       v;

    assign {n, z, c, v} = flags;

    always_comb begin
        condex = 1'b0;
        case (cond_t'(cond))
            COND_EQ: condex = z;
            COND_NE: condex = ~z;
            COND_CS: condex = c;
            COND_CC: condex = ~c;
            COND_MI: condex = n;
            COND_PL: condex = ~n;
            COND_VS: condex = v;
            COND_VC: condex = ~v;
            COND_HI: condex = c & ~z;
            COND_LS: condex = ~c | z;
            COND_GE: condex = (n == v);
            COND_LT: condex = (n != v);
            COND_GT: condex = ~z & (n == v);
            COND_LE: condex = z | (n != v);
            COND_AL: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    // Flags only move at the end of an execute cycle whose condition passed.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else begin
            if (flag_upd && condex && flagw[1]) begin
                flags[3:2] <= aluflags[3:2];
            end
            if (flag_upd && condex && flagw[0]) begin
                flags[1:0] <= aluflags[1:0];
            end
        end
    end

endmodule

// File: rtl/arm_mc_ctrl_stall.sv
// Multicycle ARM control unit with variable-latency memory handshake, stall-aware
// strobes and a sticky wait-timeout FAULT state.
module arm_mc_ctrl_stall
    import arm_mc_ctrl_stall_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic        fault
);

    localparam int unsigned CNT_W = (WAIT_TIMEOUT == 0) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_expire;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       rd_pc;
    logic       unused_rn;

    alu_dec_t   dec;
    logic       alu_op;
    logic       condex;
    logic       flag_upd;
    logic [1:0] flagw;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign funct     = Instr[13:8];
    assign rd        = Instr[3:0];
    assign rd_pc     = (rd == 4'd15);
    assign unused_rn = ^Instr[7:4];

    assign dec      = alu_decode(funct[4:1]);
    assign flag_upd = (state_q == S_EXECR) || (state_q == S_EXECI);
    assign flagw    = {funct[0], funct[0] & dec.flagw_cv};

    arm_mc_ctrl_stall_condlogic u_condlogic (
        .clk      (clk),
        .reset    (reset),
        .cond     (cond),
        .aluflags (ALUFlags),
        .flag_upd (flag_upd),
        .flagw    (flagw),
        .condex   (condex)
    );

    // Timeout fires on the last tolerated stall cycle; a same-cycle mem_ready wins.
    assign wait_expire = (WAIT_TIMEOUT != 0) && !mem_ready && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (!is_mem_state(state_q) || mem_ready) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        ResultSrc = RES_ALUOUT;
        alu_op    = 1'b0;
        fault     = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expire) begin
                    state_d = S_FAULT;
                end
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                case (op)
                    OP_MEM: state_d = S_MEMADR;
                    OP_DP:  state_d = funct[5] ? S_EXECI : S_EXECR;
                    OP_BR:  state_d = S_BRANCH;
                    OP_UND: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_expire) begin
                    state_d = S_FAULT;
                end
            end
            S_MEMWRITE: begin
                AdrSrc  = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    MemWrite = condex;
                    state_d  = S_FETCH;
                end else if (wait_expire) begin
                    state_d = S_FAULT;
                end
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = condex;
                PCWrite   = condex & rd_pc;
                state_d   = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcB = SRCB_RD2;
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB = SRCB_IMM;
                alu_op  = 1'b1;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = condex & ~dec.nowrite;
                PCWrite   = condex & rd_pc & ~dec.nowrite;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                PCWrite   = condex;
                state_d   = S_FETCH;
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A reset cycle discards any architectural update in flight.
        if (reset) begin
            MemWrite = 1'b0;
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign ALUControl = alu_op ? dec.ctrl : ALU_ADD;
    assign ImmSrc     = op;
    assign RegSrc     = {op == OP_MEM, op == OP_BR};

endmodule

// File: tb/tb_arm_mc_ctrl_stall.sv
// Scoreboard bench for arm_mc_ctrl_stall: an instruction-level model queues the
// expected per-cycle control outputs; a negedge monitor pops and compares.
module tb_arm_mc_ctrl_stall;

    localparam int WT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        mem_ready;
    logic        mem_req, MemWrite, PCWrite, IRWrite, RegWrite, AdrSrc, ALUSrcA, fault;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;

    always #5 clk = ~clk;

    arm_mc_ctrl_stall #(.WAIT_TIMEOUT(WT)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .MemWrite   (MemWrite),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .fault      (fault)
    );

    typedef struct packed {
        logic       fault;
        logic       mem_req;
        logic       MemWrite;
        logic       PCWrite;
        logic       IRWrite;
        logic       RegWrite;
        logic       AdrSrc;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ResultSrc;
        logic [1:0] ALUControl;
        logic [1:0] ImmSrc;
        logic [1:0] RegSrc;
    } outv_t;

    outv_t exp_q[$];
    bit    full_q[$];
    string tag_q[$];
    int    checks = 0;
    int    failures = 0;
    logic [3:0] mflags;

    // Monitor: one expected entry per clock; reset cycles only check that no strobe fires.
    initial begin
        outv_t e;
        outv_t a;
        bit    f;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                f = full_q.pop_front();
                t = tag_q.pop_front();
                a = {fault, mem_req, MemWrite, PCWrite, IRWrite, RegWrite, AdrSrc, ALUSrcA,
                     ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc};
                checks++;
                if (f) begin
                    if (a !== e) begin
                        failures++;
                        $display("FAIL %s @%0t: got %b want %b", t, $time, a, e);
                    end
                end else if ({a.MemWrite, a.PCWrite, a.IRWrite, a.RegWrite} !== 4'b0000) begin
                    failures++;
                    $display("FAIL %s @%0t: strobes got %b want 0000", t, $time,
                             {a.MemWrite, a.PCWrite, a.IRWrite, a.RegWrite});
                end
            end
        end
    end

    function automatic outv_t base(input logic [19:0] ins);
        outv_t e = '0;
        e.ImmSrc = ins[15:14];
        e.RegSrc = {ins[15:14] == 2'b01, ins[15:14] == 2'b10};
        return e;
    endfunction

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3];
        bit z = f[2];
        bit cy = f[1];
        bit v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Returns {ALUControl, nowrite, writes C/V}.
    function automatic logic [3:0] alu_ref(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return {2'b00, 1'b0, 1'b1};
            4'b0010: return {2'b01, 1'b0, 1'b1};
            4'b0000: return {2'b10, 1'b0, 1'b0};
            4'b1100: return {2'b11, 1'b0, 1'b0};
            4'b1010: return {2'b01, 1'b1, 1'b1};
            default: return {2'b00, 1'b1, 1'b0};
        endcase
    endfunction

    task automatic cyc(input string tag, input outv_t e, input bit full,
                       input logic rdy, input logic rst, input logic [3:0] af);
        mem_ready = rdy;
        reset     = rst;
        ALUFlags  = af;
        exp_q.push_back(e);
        full_q.push_back(full);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic fault_seq(input logic [19:0] ins);
        outv_t e = base(ins);
        e.fault = 1'b1;
        for (int i = 0; i < 3; i++) cyc("fault", e, 1, 1'($urandom), 1'b0, 4'($urandom));
        cyc("fault_rst", e, 0, 1'b1, 1'b1, 4'($urandom));
        mflags = 4'b0000;
    endtask

    // One memory access: stall cycles, then completion, timeout or a reset on the ready cycle.
    task automatic mem_access(input string tag, input outv_t e_wait, input outv_t e_done,
                              input logic [19:0] ins, input int waits, input bit rst_end,
                              output bit aborted);
        aborted = 1'b0;
        if (waits >= WT) begin
            for (int i = 0; i < WT; i++) cyc({tag, "_wait"}, e_wait, 1, 1'b0, 1'b0, 4'($urandom));
            fault_seq(ins);
            aborted = 1'b1;
        end else begin
            for (int i = 0; i < waits; i++) cyc({tag, "_wait"}, e_wait, 1, 1'b0, 1'b0, 4'($urandom));
            if (rst_end) begin
                cyc({tag, "_rst"}, e_done, 0, 1'b1, 1'b1, 4'($urandom));
                mflags = 4'b0000;
                aborted = 1'b1;
            end else begin
                cyc(tag, e_done, 1, 1'b1, 1'b0, 4'($urandom));
            end
        end
    endtask

    task automatic run_instr(input logic [19:0] ins, input int fw, input int mw,
                             input bit mrst, input logic [3:0] exaf);
        logic [3:0] cond = ins[19:16];
        logic [1:0] op = ins[15:14];
        logic [5:0] funct = ins[13:8];
        bit         rdpc = (ins[3:0] == 4'd15);
        outv_t      ew, ed, e;
        bit         ab, cx;
        logic [3:0] ar;

        Instr = ins;
        ew = base(ins);
        ew.mem_req = 1'b1; ew.ALUSrcA = 1'b1; ew.ALUSrcB = 2'b10; ew.ResultSrc = 2'b10;
        ed = ew;
        ed.IRWrite = 1'b1; ed.PCWrite = 1'b1;
        mem_access("fetch", ew, ed, ins, fw, 1'b0, ab);
        if (ab) return;

        e = base(ins);
        e.ALUSrcA = 1'b1; e.ALUSrcB = 2'b10; e.ResultSrc = 2'b10;
        cyc("decode", e, 1, 1'($urandom), 1'b0, 4'($urandom));

        cx = cond_holds(cond, mflags);
        case (op)
            2'b01: begin
                e = base(ins); e.ALUSrcB = 2'b01;
                cyc("memadr", e, 1, 1'($urandom), 1'b0, 4'($urandom));
                ew = base(ins); ew.AdrSrc = 1'b1; ew.mem_req = 1'b1;
                ed = ew;
                if (funct[0]) begin
                    mem_access("memread", ew, ed, ins, mw, mrst, ab);
                    if (!ab) begin
                        e = base(ins); e.ResultSrc = 2'b01;
                        e.RegWrite = cx; e.PCWrite = cx && rdpc;
                        cyc("memwb", e, 1, 1'($urandom), 1'b0, 4'($urandom));
                    end
                end else begin
                    ed.MemWrite = cx;
                    mem_access("memwrite", ew, ed, ins, mw, mrst, ab);
                end
            end
            2'b00: begin
                ar = alu_ref(funct[4:1]);
                e = base(ins); e.ALUSrcB = funct[5] ? 2'b01 : 2'b00; e.ALUControl = ar[3:2];
                cyc("exec", e, 1, 1'($urandom), 1'b0, exaf);
                if (cx && funct[0]) mflags[3:2] = exaf[3:2];
                if (cx && funct[0] && ar[0]) mflags[1:0] = exaf[1:0];
                cx = cond_holds(cond, mflags);
                e = base(ins);
                e.RegWrite = cx && !ar[1];
                e.PCWrite  = cx && rdpc && !ar[1];
                cyc("aluwb", e, 1, 1'($urandom), 1'b0, 4'($urandom));
            end
            2'b10: begin
                e = base(ins); e.ALUSrcB = 2'b01; e.ResultSrc = 2'b10; e.PCWrite = cx;
                cyc("branch", e, 1, 1'($urandom), 1'b0, 4'($urandom));
            end
            default: ;
        endcase
    endtask

    initial begin
        int fw, mw;
        bit mrst;
        logic [19:0] ins;

        reset = 1'b1; Instr = '0; ALUFlags = '0; mem_ready = 1'b0;
        mflags = 4'b0000;
        @(posedge clk);
        #1;
        cyc("reset", base(Instr), 0, 1'b1, 1'b1, 4'($urandom));
        cyc("reset", base(Instr), 0, 1'b1, 1'b1, 4'($urandom));

        run_instr(20'hE0821, 0, 0, 0, 4'($urandom));        // ADD R1,R2,R3
        run_instr(20'hE5912, 3, 1, 0, 4'($urandom));        // LDR, 3-cycle fetch stall
        run_instr(20'hE0500, 0, 0, 0, 4'b0100);             // SUBS R0,R0,R0 -> Z=1
        run_instr(20'h1AFFF, 1, 0, 0, 4'($urandom));        // BNE not taken
        run_instr(20'hF5812, 0, 2, 0, 4'($urandom));        // STR with Cond=1111
        run_instr(20'hE5812, 0, 0, 1, 4'($urandom));        // STR, reset on ready cycle
        run_instr(20'h0AFFF, 0, 0, 0, 4'($urandom));        // BEQ after reset: Z=0
        run_instr(20'hE591F, 0, 4, 0, 4'($urandom));        // LDR timeout -> FAULT
        run_instr(20'hE0821, 0, 0, 0, 4'($urandom));

        for (int n = 0; n < 300; n++) begin
            ins = 20'($urandom);
            if ($urandom_range(0, 3) == 0) ins[3:0] = 4'd15;
            if ($urandom_range(0, 2) == 0) ins[19:16] = 4'hE;
            fw   = ($urandom_range(0, 39) == 0) ? WT : $urandom_range(0, 3);
            mw   = ($urandom_range(0, 19) == 0) ? WT + $urandom_range(0, 2) : $urandom_range(0, 3);
            mrst = ($urandom_range(0, 24) == 0);
            run_instr(ins, fw, mw, mrst, 4'($urandom));
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
